// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// mips_pkg: load/store opcodes, access sizes and LSU state type.
// Rev 1.0
// ----------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] c_sz_byte = 2'd0;
  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_word = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_t;

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return c_sz_byte;
      OP_LH, OP_LHU, OP_SH: return c_sz_half;
      default:              return c_sz_word;
    endcase
  endfunction

  function automatic logic op_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lane);
    case (op_size(op))
      c_sz_half: return lane[0];
      c_sz_word: return lane != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------
// lsu_lane_align: little-endian lane extract/extend and store merge.
// Rev 1.0
// ----------------------------------------------------------------
module lsu_lane_align
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_size)
      c_sz_byte: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
      c_sz_half: o_load = {{16{i_signed & w_half[15]}}, w_half};
      default:   o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_size)
      c_sz_byte: o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      c_sz_half: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata;
        else           o_merged[15:0]  = i_wdata;
      end
      default: o_merged = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------
// load_store_unit: MIPS load/store initiator toward word memory.
// Rev 1.0
// ----------------------------------------------------------------
module load_store_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [5:0]  r_op;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata_lo;
  logic [31:0] r_word;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_align_word;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic        w_unused_addr_hi;

  assign req_ready        = (r_state == ST_IDLE);
  assign w_accept         = req_valid & req_ready;
  assign w_req_err        = !op_known(opcode) || op_misaligned(opcode, addr[1:0]);
  assign w_unused_addr_hi = ^addr[31:ADDR_W+2];

  // Loads extract straight from the bus on ack; MERGE works on the captured word.
  assign w_align_word = (r_state == ST_MERGE) ? r_word : mem_rdata;

  lsu_lane_align u_align (
    .i_word   (w_align_word),
    .i_lane   (r_lane),
    .i_size   (op_size(r_op)),
    .i_signed (op_signed(r_op)),
    .i_wdata  (r_wdata_lo),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                                       w_next = ST_DONE;
          else if (op_store(opcode) && op_size(opcode) == c_sz_word) w_next = ST_WRITE;
          else                                                 w_next = ST_READ;
        end
      end
      ST_READ:  if (mem_ack) w_next = op_store(r_op) ? ST_MERGE : ST_DONE;
      ST_MERGE: w_next = ST_WRITE;
      ST_WRITE: if (mem_ack) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_lane     <= '0;
      r_wdata_lo <= '0;
      r_word     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      r_state <= w_next;
      mem_req <= (w_next == ST_READ) || (w_next == ST_WRITE);
      mem_we  <= (w_next == ST_WRITE);
      done    <= (w_next == ST_DONE);
      // The only direct IDLE->DONE path is a rejected request.
      err     <= (w_next == ST_DONE) && (r_state == ST_IDLE);

      if (w_accept) begin
        r_op       <= opcode;
        r_lane     <= addr[1:0];
        r_wdata_lo <= wdata[15:0];
        mem_addr   <= addr[ADDR_W+1:2];
        if (w_next == ST_WRITE) mem_wdata <= wdata;
      end

      if (r_state == ST_READ && mem_ack) begin
        r_word <= mem_rdata;
        if (!op_store(r_op)) rdata <= w_load;
      end

      if (r_state == ST_MERGE) mem_wdata <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_load_store_unit: randomized bench with a behavioural memory/LSU model.
// Rev 1.0
// ----------------------------------------------------------------
module tb_load_store_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .addr(addr), .wdata(wdata), .done(done), .err(err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        is_load;
    logic        is_store;
    logic [31:0] rdata;
    int          base;
    int          nreq;
    int          acc;
    int          waddr;
  } txn_t;

  txn_t        q[$];
  logic [31:0] dut_mem   [0:255];
  logic [31:0] model_mem [0:255];
  logic [5:0]  ops [0:7] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int forced_waits = 0;
  int waits_total = 0, reqs_total = 0, snap_waits = 0, snap_reqs = 0;
  logic [1:0]  we_hist = '0;
  logic [31:0] model_rdata = '0;
  int last_lat = 0, last_waits = 0;
  logic last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level model: byte offset k, access size in bytes, arithmetic extension.
  task automatic model_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           output txn_t t);
    int size, k;
    bit sgn, ld, st;
    longint word, v, m, lim;
    size = 0; sgn = 0; ld = 0; st = 0;
    case (op)
      6'b100000: begin size = 1; sgn = 1; ld = 1; end
      6'b100001: begin size = 2; sgn = 1; ld = 1; end
      6'b100011: begin size = 4; ld = 1; end
      6'b100100: begin size = 1; ld = 1; end
      6'b100101: begin size = 2; ld = 1; end
      6'b101000: begin size = 1; st = 1; end
      6'b101001: begin size = 2; st = 1; end
      6'b101011: begin size = 4; st = 1; end
      default: ;
    endcase
    k = int'(a % 4);
    t.waddr    = int'((a / 4) % 256);
    t.is_load  = ld;
    t.is_store = st;
    t.rdata    = '0;
    t.acc      = 0;
    t.err      = !(ld || st) || (k % size != 0);
    word = longint'(model_mem[t.waddr]);
    if (t.err) begin
      t.base = 1; t.nreq = 0;
    end else if (ld) begin
      lim = longint'(1) << (8 * size);
      v = (word >> (8 * k)) % lim;
      if (sgn && v >= lim / 2) v = v - lim;
      t.rdata = v[31:0];
      t.base = 2; t.nreq = 1;
    end else begin
      lim = longint'(1) << (8 * size);
      m = (lim - 1) << (8 * k);
      v = (word & ~m) | ((longint'(wd) % lim) << (8 * k));
      model_mem[t.waddr] = v[31:0];
      t.base = (size == 4) ? 2 : 4;
      t.nreq = (size == 4) ? 1 : 2;
    end
  endtask

  // Memory responder: random wait states, stray acks while idle, garbage on rdata.
  bit          in_req = 0;
  int          wleft = 0;
  logic [7:0]  r_a;
  logic        r_we;
  logic [31:0] r_wd;

  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!rst_n) begin
      in_req = 0;
    end else if (mem_req) begin
      if (!in_req) begin
        in_req = 1;
        wleft  = (forced_waits >= 0) ? forced_waits
                 : ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 3));
        r_a = mem_addr; r_we = mem_we; r_wd = mem_wdata;
        reqs_total++;
        we_hist = {we_hist[0], mem_we};
        if (q.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(q[0].waddr));
        else              chk("req_without_txn", 32'(mem_req), 32'd0);
      end else begin
        chk("stable_addr", 32'(mem_addr), 32'(r_a));
        chk("stable_we", 32'(mem_we), 32'(r_we));
        if (r_we) chk("stable_wdata", mem_wdata, r_wd);
      end
      if (wleft > 0) begin
        wleft--;
        waits_total++;
      end else begin
        mem_ack = 1'b1;
        if (mem_we) dut_mem[mem_addr] = mem_wdata;
        else        mem_rdata = dut_mem[mem_addr];
        in_req = 0;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
    end
  end

  // Compare process: sampled 1 time unit after every rising edge.
  always @(posedge clk) begin
    txn_t t;
    int lat, nw, nr;
    #1;
    if (!rst_n) begin
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      model_rdata = '0;
      snap_waits  = waits_total;
      snap_reqs   = reqs_total;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          t   = q.pop_front();
          lat = cyc - t.acc + 1;
          nw  = waits_total - snap_waits;
          nr  = reqs_total - snap_reqs;
          chk("err", 32'(err), 32'(t.err));
          chk("latency", 32'(lat), 32'(t.base + nw));
          chk("mem_reqs", 32'(nr), 32'(t.nreq));
          if (t.nreq == 1) chk("req_dir", 32'(we_hist[0]), 32'(t.is_store));
          if (t.nreq == 2) chk("rmw_dir", 32'(we_hist), 32'd1);
          if (!t.err && t.is_load) model_rdata = t.rdata;
          if (!t.err && t.is_store) chk("mem_word", dut_mem[t.waddr], model_mem[t.waddr]);
          last_lat = lat; last_err = err; last_waits = nw;
          snap_waits = waits_total;
          snap_reqs  = reqs_total;
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > 40) begin
        chk("timeout_done", 32'(done), 32'd1);
        void'(q.pop_front());
      end
      chk("rdata", rdata, model_rdata);
      chk("req_ready", 32'(req_ready), 32'((q.size() == 0) && !done));
    end
  end

  task automatic do_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input bit junk);
    txn_t t;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    model_txn(op, a, wd, t);
    t.acc = cyc + 1;
    q.push_back(t);
    req_valid = 1'b1; opcode = op; addr = a; wdata = wd;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (junk) begin
        req_valid = 1'($urandom_range(0, 1));
        opcode    = ops[$urandom_range(0, 7)];
        addr      = $urandom;
        wdata     = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end while (q.size() > 0 && guard < 200);
    req_valid = 1'b0;
    if (q.size() > 0) begin
      chk("txn_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    logic [31:0] v, a;
    logic [5:0]  op;
    int guard;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      dut_mem[i] = v;
      model_mem[i] = v;
    end
    dut_mem[5]   = 32'h8899AABB;
    model_mem[5] = 32'h8899AABB;

    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    forced_waits = 0;
    do_txn(OP_LB, 32'h15, 32'h0, 0);
    chk("lb_rdata", rdata, 32'hFFFFFFAA);
    chk("lb_err", 32'(last_err), 32'd0);
    chk("lb_lat", 32'(last_lat), 32'd2);
    do_txn(OP_LHU, 32'h16, 32'h0, 0);
    chk("lhu_rdata", rdata, 32'h00008899);
    do_txn(OP_LH, 32'h16, 32'h0, 0);
    chk("lh_rdata", rdata, 32'hFFFF8899);
    do_txn(OP_SB, 32'h17, 32'h123456CC, 0);
    chk("sb_word", dut_mem[5], 32'hCC99AABB);
    chk("sb_lat", 32'(last_lat), 32'd4);
    do_txn(OP_LW, 32'h0A, 32'h0, 0);
    chk("lw_mis_err", 32'(last_err), 32'd1);
    chk("lw_mis_lat", 32'(last_lat), 32'd1);
    do_txn(OP_SH, 32'h0B, 32'h0, 0);
    chk("sh_mis_err", 32'(last_err), 32'd1);
    do_txn(6'b000000, 32'h0, 32'h0, 0);
    chk("bad_op_err", 32'(last_err), 32'd1);
    chk("err_rdata_held", rdata, 32'hFFFF8899);
    forced_waits = 3;
    do_txn(OP_SW, 32'h08, 32'hDEADBEEF, 0);
    chk("sw_word", dut_mem[2], 32'hDEADBEEF);
    chk("sw_waits", 32'(last_waits), 32'd3);
    chk("sw_lat", 32'(last_lat), 32'd5);

    forced_waits = -1;
    repeat (300) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      op = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      do_txn(op, a, $urandom, 1);
    end

    // Abort a store while it waits in WRITE.
    forced_waits = 30;
    begin
      txn_t t;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
      model_txn(OP_SW, 32'h10, 32'hA5A5F00D, t);
      t.acc = cyc + 1;
      q.push_back(t);
      req_valid = 1'b1; opcode = OP_SW; addr = 32'h10; wdata = 32'hA5A5F00D;
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!(mem_req && mem_we) && guard < 20) begin @(negedge clk); guard++; end
      chk("abort_in_write", 32'(mem_req && mem_we), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("async_mem_req", 32'(mem_req), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      model_mem[4] = dut_mem[4];
      forced_waits = 0;
      @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);
    end
    do_txn(OP_SW, 32'h0C, 32'h5A5A1234, 0);
    do_txn(OP_LW, 32'h0C, 32'h0, 0);
    chk("lw_after_reset", rdata, 32'h5A5A1234);
    chk("lw_after_reset_lat", 32'(last_lat), 32'd2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not terminate");
  end

endmodule
`default_nettype wire
